// File: rtl/cap_sense_pkg.sv
// Shared types and default timing constants for the capacitance sense controller.
package cap_sense_pkg;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        CHARGE = 1'b1
    } cap_state_e;

    // Defaults for a 4 MHz system clock (5 ms each).
    localparam int CAP_TIMEOUT_4MHZ = 20000;
    localparam int CAP_SETTLE_4MHZ  = 20000;

endpackage

// File: rtl/cap_sense_filter.sv
// One comparator input: SYNC_STAGES-deep synchroniser followed by a stability
// filter that only follows the synced value after FILT_CYC consecutive differing cycles.
module cap_sense_filter
    import cap_sense_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic filt_out
);

    localparam int FCW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FCW-1:0]         stab_q, stab_d;
    logic                   filt_q, filt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        filt_d = filt_q;
        stab_d = '0;
        // Any cycle where the synced value agrees with the output restarts the count.
        if (synced != filt_q) begin
            if (stab_q == FCW'(FILT_CYC - 1)) begin
                filt_d = synced;
            end else begin
                stab_d = stab_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            stab_q <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            stab_q <= stab_d;
            filt_q <= filt_d;
        end
    end

    assign filt_out = filt_q;

endmodule

// File: rtl/cap_sense_ctrl.sv
// Capacitance comparator front-end: deglitch, hysteresis, reference toggling and
// charge-time measurement. Define CAP_AVG_EN to report block averages of 2^AVG_LOG2 samples.
module cap_sense_ctrl
    import cap_sense_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = CAP_TIMEOUT_4MHZ,
    parameter int SETTLE_CYC  = CAP_SETTLE_4MHZ,
    parameter int AVG_LOG2    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pos_comparator,
    input  logic             neg_comparator,
    output logic             reference,
    output logic             antibounce,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             overflow
);

    if (SYNC_STAGES < 2 || FILT_CYC < 1 || AVG_LOG2 < 1 || TIMEOUT < 1 ||
        SETTLE_CYC < 1 || CNT_W > 31 || TIMEOUT >= (1 << CNT_W)) begin : g_param_check
        $error("cap_sense_ctrl: illegal parameter combination");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic filt_pos, filt_neg;

    cap_sense_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYC    (FILT_CYC)
    ) u_filt_pos (
        .clock    (clock),
        .reset    (reset),
        .async_in (pos_comparator),
        .filt_out (filt_pos)
    );

    cap_sense_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYC    (FILT_CYC)
    ) u_filt_neg (
        .clock    (clock),
        .reset    (reset),
        .async_in (neg_comparator),
        .filt_out (filt_neg)
    );

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hyst_q, hyst_d;
    logic             ref_q, ref_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pvalid_q, pvalid_d;
    logic             ovf_q, ovf_d;

    logic             settled;
    logic             meas_evt;
    logic             meas_tmo;
    logic [CNT_W-1:0] meas_val;

    assign settled = (hyst_q == ref_q);

    // Inside the window, or an inconsistent pos=1/neg=0 pair, holds the last level.
    always_comb begin
        hyst_d = hyst_q;
        if (filt_pos && filt_neg) begin
            hyst_d = 1'b1;
        end else if (!filt_pos && !filt_neg) begin
            hyst_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ref_d    = ref_q;
        meas_evt = 1'b0;
        meas_tmo = 1'b0;
        meas_val = cnt_q;
        case (state_q)
            SETTLE: begin
                if (!settled) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    ref_d   = ~ref_q;
                    cnt_d   = '0;
                    state_d = CHARGE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            CHARGE: begin
                // A crossing takes priority over a coincident timeout.
                if (settled) begin
                    meas_evt = 1'b1;
                    meas_val = cnt_q;
                    cnt_d    = '0;
                    state_d  = SETTLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    meas_evt = 1'b1;
                    meas_tmo = 1'b1;
                    meas_val = CNT_W'(TIMEOUT);
                    ref_d    = ~ref_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef CAP_AVG_EN
    localparam int SUM_W = CNT_W + AVG_LOG2;

    logic [SUM_W-1:0]    sum_q, sum_d, sum_next;
    logic [AVG_LOG2-1:0] smp_q, smp_d;
    logic                ovf_acc_q, ovf_acc_d;

    always_comb begin
        sum_next  = sum_q + SUM_W'(meas_val);
        sum_d     = sum_q;
        smp_d     = smp_q;
        ovf_acc_d = ovf_acc_q;
        period_d  = period_q;
        pvalid_d  = 1'b0;
        ovf_d     = 1'b0;
        if (meas_evt) begin
            if (&smp_q) begin
                period_d  = sum_next[SUM_W-1:AVG_LOG2];
                pvalid_d  = 1'b1;
                ovf_d     = ovf_acc_q | meas_tmo;
                sum_d     = '0;
                smp_d     = '0;
                ovf_acc_d = 1'b0;
            end else begin
                sum_d     = sum_next;
                smp_d     = smp_q + AVG_LOG2'(1);
                ovf_acc_d = ovf_acc_q | meas_tmo;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q     <= '0;
            smp_q     <= '0;
            ovf_acc_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            smp_q     <= smp_d;
            ovf_acc_q <= ovf_acc_d;
        end
    end
`else
    always_comb begin
        period_d = meas_evt ? meas_val : period_q;
        pvalid_d = meas_evt;
        ovf_d    = meas_tmo;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            hyst_q   <= 1'b0;
            ref_q    <= 1'b0;
            period_q <= '0;
            pvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hyst_q   <= hyst_d;
            ref_q    <= ref_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign reference    = ref_q;
    assign antibounce   = settled;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_cap_sense_ctrl.sv
// Directed bench for cap_sense_ctrl with short timing (TIMEOUT=100, SETTLE_CYC=20).
module tb_cap_sense_ctrl;

    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             pos   = 1'b0;
    logic             neg   = 1'b0;
    logic             reference;
    logic             antibounce;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int v0      = 0;

    always #5 clock = ~clock;

    cap_sense_ctrl #(
        .SYNC_STAGES (2),
        .FILT_CYC    (3),
        .CNT_W       (CNT_W),
        .TIMEOUT     (100),
        .SETTLE_CYC  (20),
        .AVG_LOG2    (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pos_comparator (pos),
        .neg_comparator (neg),
        .reference      (reference),
        .antibounce     (antibounce),
        .period         (period),
        .period_valid   (period_valid),
        .overflow       (overflow)
    );

    always @(negedge clock) begin
        if (period_valid === 1'b1) n_valid <= n_valid + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

`ifdef CAP_AVG_EN
    // From one cycle after a toggle: change inputs so the synchroniser first sees
    // them d edges after the toggle, and return one cycle after the capture edge.
    task automatic measure(input int d, input logic lvl);
        tick(d - 1);
        pos = lvl;
        neg = lvl;
        tick(7);
    endtask
`endif

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_reference", 32'(reference), 32'd0);
        chk("rst_antibounce", 32'(antibounce), 32'd1);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_valid", 32'(period_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        @(negedge clock);
        reset = 1'b0;
        tick(19);
        chk("settle_no_toggle_yet", 32'(reference), 32'd0);
        tick(1);
        chk("settle_toggle_ref", 32'(reference), 32'd1);
        chk("charge_antibounce_low", 32'(antibounce), 32'd0);

`ifdef CAP_AVG_EN
        v0 = n_valid;
        measure(9, 1'b1);
        tick(20);
        measure(10, 1'b0);
        tick(20);
        measure(11, 1'b1);
        chk("avg_no_strobe_3", 32'(period_valid), 32'd0);
        chk("avg_period_held", 32'(period), 32'd0);
        chk("avg_count_3", 32'(n_valid - v0), 32'd0);
        tick(20);
        measure(12, 1'b0);
        chk("avg_strobe", 32'(period_valid), 32'd1);
        chk("avg_period", 32'(period), 32'd15);
        chk("avg_overflow", 32'(overflow), 32'd0);
        tick(1);
        chk("avg_count_4", 32'(n_valid - v0), 32'd1);
`else
        // Crossing at D=10 -> period 15.
        tick(9);
        pos = 1'b1;
        neg = 1'b1;
        v0  = n_valid;
        tick(5);
        chk("d10_ab_before", 32'(antibounce), 32'd0);
        tick(1);
        chk("d10_ab_rise", 32'(antibounce), 32'd1);
        chk("d10_no_early_valid", 32'(period_valid), 32'd0);
        tick(1);
        chk("d10_valid", 32'(period_valid), 32'd1);
        chk("d10_period", 32'(period), 32'd15);
        chk("d10_overflow", 32'(overflow), 32'd0);
        chk("d10_ref_hold", 32'(reference), 32'd1);
        tick(1);
        chk("d10_valid_drop", 32'(period_valid), 32'd0);
        chk("d10_single_strobe", 32'(n_valid - v0), 32'd1);

        // Bounce during SETTLE restarts the settle count.
        pos = 1'b0;
        neg = 1'b0;
        tick(5);
        chk("bounce_ab_pre", 32'(antibounce), 32'd1);
        pos = 1'b1;
        neg = 1'b1;
        tick(1);
        chk("bounce_ab_low", 32'(antibounce), 32'd0);
        tick(5);
        chk("bounce_ab_back", 32'(antibounce), 32'd1);
        tick(8);
        chk("bounce_no_early_toggle", 32'(reference), 32'd1);
        tick(11);
        chk("bounce_toggle_pending", 32'(reference), 32'd1);
        tick(1);
        chk("bounce_toggle", 32'(reference), 32'd0);

        // No crossing -> timeout, then the toggled reference matches and captures 0.
        tick(99);
        chk("tmo_pre_ref", 32'(reference), 32'd0);
        chk("tmo_pre_valid", 32'(period_valid), 32'd0);
        tick(1);
        chk("tmo_valid", 32'(period_valid), 32'd1);
        chk("tmo_period", 32'(period), 32'd100);
        chk("tmo_overflow", 32'(overflow), 32'd1);
        chk("tmo_ref_toggle", 32'(reference), 32'd1);
        tick(1);
        chk("tmo_next_valid", 32'(period_valid), 32'd1);
        chk("tmo_next_period", 32'(period), 32'd0);
        chk("tmo_next_overflow", 32'(overflow), 32'd0);

        // 2-cycle glitch is ignored, a stable change at D=20 gives period 25.
        tick(19);
        chk("g_pre_toggle", 32'(reference), 32'd1);
        tick(1);
        chk("g_toggle", 32'(reference), 32'd0);
        v0  = n_valid;
        pos = 1'b0;
        neg = 1'b0;
        tick(2);
        pos = 1'b1;
        neg = 1'b1;
        tick(8);
        chk("g_ab_unchanged", 32'(antibounce), 32'd0);
        chk("g_no_strobe", 32'(n_valid - v0), 32'd0);
        tick(9);
        pos = 1'b0;
        neg = 1'b0;
        tick(6);
        chk("d20_ab_rise", 32'(antibounce), 32'd1);
        chk("d20_no_early_valid", 32'(period_valid), 32'd0);
        tick(1);
        chk("d20_valid", 32'(period_valid), 32'd1);
        chk("d20_period", 32'(period), 32'd25);
        chk("d20_overflow", 32'(overflow), 32'd0);

        // Reset in the middle of CHARGE.
        tick(20);
        chk("mid_toggle", 32'(reference), 32'd1);
        tick(10);
        #2;
        reset = 1'b1;
        #1;
        v0 = n_valid;
        chk("mid_rst_reference", 32'(reference), 32'd0);
        chk("mid_rst_antibounce", 32'(antibounce), 32'd1);
        chk("mid_rst_period", 32'(period), 32'd0);
        chk("mid_rst_valid", 32'(period_valid), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        tick(3);
        chk("mid_rst_no_strobe", 32'(n_valid - v0), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick(19);
        chk("post_rst_no_toggle", 32'(reference), 32'd0);
        tick(1);
        chk("post_rst_toggle", 32'(reference), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
